// File: rtl/seq_scan_pkg.sv
// -----------------------------------------------------------------------------
// seq_scan_pkg
// Shared encodings and constants for the serial "101" scan controller.
//   ctrl_state_t : controller FSM states (IDLE, LOAD, SHIFT, DONE)
//   det_state_t  : pattern detector states (S0..S3)
//   BYTE_W       : width of one frame byte
//   BIT_CNT_W    : width of the per-byte bit counter
// -----------------------------------------------------------------------------
package seq_scan_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = $clog2(BYTE_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_t;

    typedef enum logic [1:0] {
        DET_S0 = 2'd0,
        DET_S1 = 2'd1,
        DET_S2 = 2'd2,
        DET_S3 = 2'd3
    } det_state_t;

endpackage

// File: rtl/seq_match_core.sv
// -----------------------------------------------------------------------------
// seq_match_core
// Moore "101" detector fed one bit at a time.
// Configuration macro: SEQ_SCAN_OVERLAP_EN
//   defined   -> S3 on 0 goes to S2, so overlapping matches are counted
//   undefined -> S3 on 0 goes to S0, matches do not overlap
// Ports:
//   clk    in  : clock, rising edge
//   rst    in  : synchronous active-high reset (to S0)
//   clr    in  : synchronous clear to S0 (frame start)
//   bit_en in  : bit_in is a valid detector input this cycle
//   bit_in in  : serial data bit
//   z      out : high while the detector sits in S3
//   hit    out : combinational, high when this enabled bit moves the detector into S3
// -----------------------------------------------------------------------------
module seq_match_core
    import seq_scan_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic bit_en,
    input  logic bit_in,
    output logic z,
    output logic hit
);

    det_state_t state;
    det_state_t state_next;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        if (bit_en) begin
            unique case (state)
                DET_S0: state_next = bit_in ? DET_S1 : DET_S0;
                DET_S1: state_next = bit_in ? DET_S1 : DET_S2;
                DET_S2: state_next = bit_in ? DET_S3 : DET_S0;
                DET_S3: begin
`ifdef SEQ_SCAN_OVERLAP_EN
                    // The trailing '1' of a match can open the next one.
                    state_next = bit_in ? DET_S1 : DET_S2;
`else
                    state_next = bit_in ? DET_S1 : DET_S0;
`endif
                end
                default: state_next = DET_S0;
            endcase
        end
    end

    // hit is qualified by bit_en so a stalled cycle sitting in S3 never recounts.
    assign hit = bit_en && (state_next == DET_S3);
    assign z   = (state == DET_S3);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, matching the hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DET_S0;
        end else if (clr) begin
            state <= DET_S0;
        end else begin
            state <= state_next;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seq_scan_ctrl
// Accepts FRAME_LEN bytes over a valid/ready handshake, serialises each byte
// MSB first into a "101" detector and counts matches over the whole frame.
// Configuration macro: SEQ_SCAN_OVERLAP_EN (see seq_match_core).
// Parameters:
//   FRAME_LEN : bytes per frame (>=1)
//   CNT_W     : match counter width (>=2), saturates at all-ones
// Ports:
//   clk        in  : clock, rising edge
//   rst        in  : synchronous active-high reset, highest priority
//   start      in  : frame start request, only honoured in IDLE
//   data_in    in  : frame byte
//   data_valid in  : data_in valid
//   data_ready out : byte accept (high in LOAD)
//   busy       out : high in every state except IDLE
//   done       out : one-cycle frame-complete pulse
//   match_cnt  out : matches in the current or last frame
//   z          out : detector Moore output (state S3)
// -----------------------------------------------------------------------------
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              z
);

    // A one-byte frame still needs a counter bit to keep widths legal.
    localparam int BYTE_CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    ctrl_state_t           state;
    ctrl_state_t           state_next;
    logic [BYTE_W-1:0]     shift_reg;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic                  det_clr;
    logic                  shift_en;
    logic                  det_hit;
    logic                  last_bit;
    logic                  last_byte;
    logic                  load_xfer;

    assign last_bit  = (bit_cnt == BIT_CNT_W'(BYTE_W - 1));
    assign last_byte = (byte_cnt == BYTE_CNT_W'(FRAME_LEN - 1));
    assign load_xfer = (state == ST_LOAD) && data_valid;

    // Controller: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Controller: next state and Moore outputs.
    always_comb begin
        state_next = state;
        data_ready = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        det_clr    = 1'b0;
        shift_en   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    det_clr    = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (last_bit) begin
                    state_next = last_byte ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath. The shift register is reset along with the counters so the
    // detector input is a known value straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            match_cnt <= '0;
        end else begin
            if (det_clr) begin
                byte_cnt  <= '0;
                match_cnt <= '0;
            end
            if (load_xfer) begin
                shift_reg <= data_in;
                bit_cnt   <= '0;
            end
            if (shift_en) begin
                shift_reg <= shift_reg << 1;
                bit_cnt   <= bit_cnt + 1'b1;
                if (last_bit && !last_byte) begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
            // Saturating count; the edge that enters S3 is the counting edge.
            if (det_hit && (match_cnt != {CNT_W{1'b1}})) begin
                match_cnt <= match_cnt + 1'b1;
            end
        end
    end

    seq_match_core u_match_core (
        .clk    (clk),
        .rst    (rst),
        .clr    (det_clr),
        .bit_en (shift_en),
        .bit_in (shift_reg[BYTE_W-1]),
        .z      (z),
        .hit    (det_hit)
    );

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_scan_ctrl
// Scoreboard bench for seq_scan_ctrl (FRAME_LEN=2, CNT_W=2). The stimulus
// process launches frames and pushes the expected outcome; a monitor pops and
// compares whenever done pulses. Expected counts come from a plain scan of the
// frame's bit string for "101".
// -----------------------------------------------------------------------------
module tb_seq_scan_ctrl;

    localparam int FL    = 2;
    localparam int CW    = 2;
    localparam int MAXC  = (1 << CW) - 1;
    localparam int NBITS = 8 * FL;
`ifdef SEQ_SCAN_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    data_in;
    logic          data_valid;
    logic          data_ready;
    logic          busy;
    logic          done;
    logic [CW-1:0] match_cnt;
    logic          z;

    seq_scan_ctrl #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .done       (done),
        .match_cnt  (match_cnt),
        .z          (z)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cnt;
        bit z_last;
        bit z_any;
        int lat;
        int start_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_done   = 0;
    int   n_frames = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: scan the bit string for "101". With overlap the last '1' of a
    // match may start the next one; without, the search resumes after it.
    function automatic void ref_model(input logic [NBITS-1:0] frame,
                                      output int cnt, output bit zl);
        int i;
        cnt = 0;
        zl  = 1'b0;
        i   = 0;
        while (i + 2 < NBITS) begin
            if (frame[NBITS-1-i] && !frame[NBITS-2-i] && frame[NBITS-3-i]) begin
                cnt++;
                if (i + 2 == NBITS - 1) zl = 1'b1;
                i += OVERLAP ? 2 : 3;
            end else begin
                i++;
            end
        end
    endfunction

    // Monitor: tracks z during the frame and scores each done pulse.
    bit z_seen = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            z_seen = 1'b0;
        end else begin
            if (busy && z) z_seen = 1'b1;
            if (done) begin
                n_done++;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_done: done pulsed with no frame outstanding (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("match_cnt", match_cnt, e.cnt);
                    check("z_at_done", z, e.z_last);
                    check("z_any_in_frame", z_seen, e.z_any);
                    check("done_latency", cyc - e.start_cyc, e.lat);
                end
                z_seen = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!data_ready && n < 50) begin
            tick();
            n++;
        end
        ok = data_ready;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: data_ready stayed 0 for %0d cycles", n);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: busy stayed 1 for %0d cycles", n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_data_ready"}, data_ready, 0);
        check({tag, "_z"}, z, 0);
        check({tag, "_match_cnt"}, match_cnt, 0);
    endtask

    // Runs one frame. stall_max > 0 adds random LOAD stalls per byte;
    // stall_at/stall_n forces a fixed stall on one byte.
    task automatic run_frame(input logic [NBITS-1:0] frame, input int stall_max,
                             input int stall_at, input int stall_n,
                             input bit start_mid, input bit rst_mid);
        int   st[FL];
        int   total;
        int   raw;
        bit   zl;
        bit   ok;
        exp_t e;
        total = 0;
        for (int i = 0; i < FL; i++) begin
            st[i] = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
            if (i == stall_at) st[i] += stall_n;
            total += st[i];
        end
        ref_model(frame, raw, zl);

        start = 1'b1;
        tick();
        start = 1'b0;
        e.cnt       = (raw > MAXC) ? MAXC : raw;
        e.z_last    = zl;
        e.z_any     = (raw > 0);
        e.lat       = 9 * FL + total;
        e.start_cyc = cyc;
        sb_q.push_back(e);
        n_frames++;

        for (int i = 0; i < FL; i++) begin
            wait_ready(ok);
            if (!ok) break;
            repeat (st[i]) tick();
            data_in    = frame[NBITS-1-8*i -: 8];
            data_valid = 1'b1;
            tick();
            data_valid = 1'b0;
            data_in    = 8'($urandom);
            if (i == 0 && start_mid) begin
                tick();
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            if (i == FL - 1 && rst_mid) begin
                repeat (3) tick();
                rst = 1'b1;
                tick();
                check_reset_outputs("mid_rst");
                rst = 1'b0;
                void'(sb_q.pop_back());
                n_frames--;
                return;
            end
        end
        wait_idle();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        data_in    = 8'h00;
        data_valid = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single-byte style pattern padded with zeros, cross-byte, all-zero,
        // saturation, and a five-cycle stall on byte 2.
        run_frame(16'hAA00, 0, -1, 0, 1'b0, 1'b0);
        run_frame(16'h0140, 0, -1, 0, 1'b0, 1'b0);
        run_frame(16'h0000, 0, -1, 0, 1'b0, 1'b0);
        run_frame(16'hAAAA, 0, -1, 0, 1'b0, 1'b0);
        run_frame(16'hAAAA, 0,  1, 5, 1'b0, 1'b0);
        run_frame(16'h0540, 0,  1, 5, 1'b0, 1'b0);

        // Reset during shift of byte 2, then a clean frame.
        run_frame(16'hAAAA, 0, -1, 0, 1'b0, 1'b1);
        run_frame(16'h0140, 0, -1, 0, 1'b0, 1'b0);

        // start while busy must be ignored.
        run_frame(16'hA55A, 0, -1, 0, 1'b1, 1'b0);
        repeat (30) tick();

        for (int k = 0; k < 40; k++) begin
            logic [NBITS-1:0] f;
            f = NBITS'($urandom);
            run_frame(f, 3, -1, 0, 1'b0, 1'b0);
        end

        repeat (20) tick();
        check("scoreboard_empty", sb_q.size(), 0);
        check("done_count", n_done, n_frames);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 4, meaning bytes per scan frame (>=1).
REQ-002 SHALL have parameter CNT_W, default 8, meaning match counter width (>=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  frame start request, sampled only in IDLE.
REQ-006 SHALL have port data_in  input  8  frame byte, serialized MSB first.
REQ-007 SHALL have port data_valid  input  1  data_in valid.
REQ-008 SHALL have port data_ready  output  1  byte accept; a transfer occurs when data_valid and data_ready are both high at a clk edge.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  one-cycle frame-complete pulse.
REQ-011 SHALL have port match_cnt  output  CNT_W  count of "101" matches in the current or last frame.
REQ-012 SHALL have port z  output  1  Moore detector output, high while the detector is in S3.

Function
REQ-013 Controller FSM SHALL have states IDLE, LOAD, SHIFT, DONE.
REQ-014 IDLE: start=1 -> LOAD; clear match_cnt, byte counter and detector (to S0); data_valid ignored.
REQ-015 LOAD: data_ready=1; on transfer, capture data_in into shift register, bit counter=0 -> SHIFT; with no transfer, hold state and detector.
REQ-016 SHIFT: data_ready=0; each cycle present shift_reg[7] to the detector as one enabled bit, shift left; after the 8th bit -> LOAD if byte counter < FRAME_LEN-1 (increment counter), else -> DONE.
REQ-017 DONE: done=1 for exactly one cycle -> IDLE; match_cnt holds its value until the next accepted start.
REQ-018 Detector states S0..S3; transitions only on an enabled bit: S0: 1->S1, 0->S0; S1: 1->S1, 0->S2; S2: 1->S3, 0->S0; S3: 1->S1, 0 per REQ-026.
REQ-019 Detector state SHALL persist across byte boundaries within a frame; a pattern spanning two bytes counts.
REQ-020 match_cnt SHALL increment at the same edge on which an enabled bit moves the detector into S3; it saturates at all-ones.
REQ-021 With data_valid held high, done SHALL assert 9*FRAME_LEN cycles after the edge that samples start; each LOAD stall cycle adds one cycle.
REQ-022 start asserted while busy SHALL be ignored.

Reset
REQ-023 rst SHALL take priority over all other inputs, including mid-frame.
REQ-024 Reset values: FSM IDLE, detector S0, data_ready 0, busy 0, done 0, z 0, match_cnt 0, counters and shift register 0.
REQ-025 After rst deasserts, the block SHALL accept start on the next edge; no partial frame resumes.

Configuration
REQ-026 Macro SEQ_SCAN_OVERLAP_EN defined: S3 on 0 -> S2 (overlapping matches counted); undefined: S3 on 0 -> S0 (non-overlapping).

Structure
REQ-027 Package seq_scan_pkg SHALL hold the controller state and detector state encodings and the constant BYTE_W=8.
REQ-028 The detector SHALL be a sub-module, seq_match_core (clk, rst, clr, bit_en, bit_in, z, hit), with hit a combinational flag for next-state==S3 under bit_en.

Verification
REQ-029 FRAME_LEN=1, byte 8'hAA, overlap enabled -> match_cnt=3, done 9 cycles after start; overlap disabled -> match_cnt=2.
REQ-030 FRAME_LEN=2, bytes 8'h01 then 8'h40 -> match_cnt=1 (cross-byte match); bytes 8'h00, 8'h00 -> match_cnt=0, z never high.
REQ-031 CNT_W=2, FRAME_LEN=2, bytes 8'hAA, 8'hAA, overlap enabled -> 7 matches saturate to match_cnt=3.
REQ-032 data_valid low 5 cycles in LOAD mid-frame -> detector state unchanged, done delayed exactly 5 cycles, match_cnt equal to unstalled run.
REQ-033 rst pulsed during SHIFT of byte 2 -> next cycle all outputs at REQ-024 values; a subsequent start produces a correct full frame.
REQ-034 start pulsed during SHIFT -> ignored; no second frame, done pulses once.
